ahb_mem_slave: RTL and testbench

//  AHB-Lite memory slave; the downstream stage of the AHB master (mast). It consumes

---
 rtl/ahb_pkg.sv | 37 +++
 rtl/ahb_sram_array.sv | 57 +++++
 rtl/ahb_mem_slave.sv | 167 ++++++++++++++++
 tb/tb_ahb_mem_slave.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite definitions: transfer types, size codes, response codes,
// slave FSM states and the byte-lane mask helper.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ERR1,
        ST_ERR2
    } slave_state_t;

    // Byte lanes touched by a transfer of the given size at byte offset a.
    function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] a);
        logic [3:0] m;
        case (size)
            HSIZE_BYTE: m = 4'b0001 << a;
            HSIZE_HALF: m = 4'b0011 << {a[1], 1'b0};
            default:    m = 4'hF;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/ahb_sram_array.sv
// Word memory with 4-bit byte-enable write and a registered read port.
// Bytes written on the same edge as a read of the same word are forwarded,
// so a read issued alongside a write always sees the new data.
module ahb_sram_array #(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          hclk,
    input  logic          hresetn,
    input  logic [3:0]    we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];
    logic [31:0] merged;
    logic [31:0] rdata_q;
    logic [31:0] rdata_d;

    // Per-lane forwarding of same-edge write data onto the read word
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign merged[8*gi +: 8] = (we[gi] && (waddr == raddr)) ? wdata[8*gi +: 8]
                                                                : mem[raddr][8*gi +: 8];
    end

    // Byte-enable write into the array (contents are never reset)
    always_ff @(posedge hclk) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) begin
                mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    // Read data is loaded only when a read is issued, otherwise held
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = merged;
        end
    end

    // Read data register
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/ahb_mem_slave.sv
// AHB-Lite memory slave: address decode, wait-state / two-cycle ERROR FSM,
// and byte-lane writes into an ahb_sram_array.
module ahb_mem_slave
    import ahb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          DEPTH       = 256,
    parameter int          WAIT_STATES = 0
) (
    input  logic        hclk,
    input  logic        hresetn,
    input  logic        hsel,
    input  logic [31:0] haddr,
    input  logic [1:0]  htrans,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic [2:0]  hburst,
    input  logic [31:0] hwdata,
    output logic        hready,
    output logic        hresp,
    output logic [31:0] hrdata
);

    localparam int          AW        = $clog2(DEPTH);
    localparam logic [32:0] SPAN      = 33'(4 * DEPTH);
    localparam logic [2:0]  WAIT_LOAD = 3'(WAIT_STATES - 1);

    slave_state_t  state_q, state_d;
    logic [2:0]    cnt_q, cnt_d;
    logic          pend_q, pend_d;
    logic          write_q, write_d;
    logic          err_q, err_d;
    logic [2:0]    size_q, size_d;
    logic [AW-1:0] widx_q, widx_d;
    logic [1:0]    boff_q, boff_d;

    logic [31:0]   offset;
    logic          misaligned;
    logic          addr_err;
    logic          accept;
    logic [AW-1:0] widx_in;
    logic [3:0]    mem_we;
    logic          mem_re;
    logic [AW-1:0] mem_raddr;
    logic          unused_bits;

    // Burst type and the SEQ/NONSEQ distinction do not affect this slave
    assign unused_bits = ^{hburst, htrans[0]};

    // Address-phase decode: range, size and alignment checks
    always_comb begin
        offset     = haddr - BASE_ADDR;
        misaligned = ((hsize == HSIZE_HALF) && haddr[0]) ||
                     ((hsize == HSIZE_WORD) && (haddr[1:0] != 2'b00));
        addr_err   = (haddr < BASE_ADDR) || ({1'b0, offset} >= SPAN) ||
                     (hsize > HSIZE_WORD) || misaligned;
    end

    assign widx_in = offset[AW+1:2];
    assign accept  = hsel && hready && htrans[1];

    // Bus response is a pure function of the FSM state
    always_comb begin
        hready = !((state_q == ST_WAIT) || (state_q == ST_ERR1));
        hresp  = ((state_q == ST_ERR1) || (state_q == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
    end

    // Next-state: address-phase capture and wait/error sequencing
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        write_d = write_q;
        err_d   = err_q;
        size_d  = size_q;
        widx_d  = widx_q;
        boff_d  = boff_q;

        if (hready) begin
            pend_d = accept;
            if (accept) begin
                write_d = hwrite;
                err_d   = addr_err;
                size_d  = hsize;
                widx_d  = widx_in;
                boff_d  = haddr[1:0];
            end
        end

        case (state_q)
            ST_IDLE, ST_ERR2: begin
                state_d = ST_IDLE;
                if (accept) begin
                    if (addr_err) begin
                        state_d = ST_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_LOAD;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 3'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            ST_ERR1: state_d = ST_ERR2;
            default: state_d = ST_IDLE;
        endcase
    end

    // State and address-phase registers
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
            size_q  <= '0;
            widx_q  <= '0;
            boff_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            write_q <= write_d;
            err_q   <= err_d;
            size_q  <= size_d;
            widx_q  <= widx_d;
            boff_q  <= boff_d;
        end
    end

    // Memory strobes: writes commit at the end of the completing cycle; reads
    // are issued on the edge into the completing cycle
    always_comb begin
        mem_we = '0;
        if (hready && pend_q && write_q && !err_q) begin
            mem_we = lane_mask(size_q, boff_q);
        end
        if (WAIT_STATES == 0) begin
            mem_re    = accept && !addr_err && !hwrite;
            mem_raddr = widx_in;
        end else begin
            mem_re    = (state_q == ST_WAIT) && (cnt_q == 3'd0) && !write_q;
            mem_raddr = widx_q;
        end
    end

    ahb_sram_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_sram (
        .hclk    (hclk),
        .hresetn (hresetn),
        .we      (mem_we),
        .waddr   (widx_q),
        .wdata   (hwdata),
        .re      (mem_re),
        .raddr   (mem_raddr),
        .rdata   (hrdata)
    );

endmodule

// File: tb/tb_ahb_mem_slave.sv
// Scoreboard bench for ahb_mem_slave: one zero-wait and one two-wait instance.
module tb_ahb_mem_slave;
    import ahb_pkg::*;

    localparam logic [1:0] T_IDLE   = 2'b00;
    localparam logic [1:0] T_BUSY   = 2'b01;
    localparam logic [1:0] T_NONSEQ = 2'b10;
    localparam logic [1:0] T_SEQ    = 2'b11;

    logic        hclk = 1'b0;
    logic        hresetn = 1'b0;
    logic        hsel = 1'b1;
    logic [31:0] haddr = '0;
    logic [1:0]  htrans = T_IDLE;
    logic        hwrite = 1'b0;
    logic [2:0]  hsize = HSIZE_WORD;
    logic [2:0]  hburst = 3'b011;
    logic [31:0] hwdata = '0;
    logic        sel = 1'b0;

    logic        hready0, hresp0, hready2, hresp2;
    logic [31:0] hrdata0, hrdata2;
    logic        hready_m, hresp_m;
    logic [31:0] hrdata_m;

    assign hready_m = sel ? hready2 : hready0;
    assign hresp_m  = sel ? hresp2  : hresp0;
    assign hrdata_m = sel ? hrdata2 : hrdata0;

    always #5 hclk = ~hclk;

    ahb_mem_slave #(.BASE_ADDR(32'h0), .DEPTH(256), .WAIT_STATES(0)) u_dut0 (
        .hclk(hclk), .hresetn(hresetn), .hsel(hsel & ~sel), .haddr(haddr),
        .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hburst(hburst),
        .hwdata(hwdata), .hready(hready0), .hresp(hresp0), .hrdata(hrdata0)
    );

    ahb_mem_slave #(.BASE_ADDR(32'h0), .DEPTH(256), .WAIT_STATES(2)) u_dut2 (
        .hclk(hclk), .hresetn(hresetn), .hsel(hsel & sel), .haddr(haddr),
        .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hburst(hburst),
        .hwdata(hwdata), .hready(hready2), .hresp(hresp2), .hrdata(hrdata2)
    );

    typedef struct {
        int          waits;
        logic        resp;
        logic        chk;
        logic [31:0] data;
        int          tag;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   tag_cnt  = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, got, want);
        end
    endtask

    function automatic int ws();
        return sel ? 2 : 0;
    endfunction

    // Present one address phase, wait for it to be sampled, queue its expected response
    task automatic xfer(input logic [1:0] tr, input logic [31:0] a, input logic w,
                        input logic [2:0] sz, input logic [31:0] wd, input int waits,
                        input logic resp, input logic chk, input logic [31:0] rd);
        exp_t e;
        int   n;
        haddr  = a;
        htrans = tr;
        hwrite = w;
        hsize  = sz;
        n = 0;
        @(negedge hclk);
        while (!hready_m && n < 40) begin
            @(negedge hclk);
            n++;
        end
        if (n >= 40) begin
            n_checks++;
            n_fail++;
            $display("FAIL addr_phase_timeout: hready low %0d cycles, required high", n);
        end
        @(posedge hclk);
        tag_cnt++;
        e.waits = waits;
        e.resp  = resp;
        e.chk   = chk;
        e.data  = rd;
        e.tag   = tag_cnt;
        exp_q.push_back(e);
        #1 hwdata = wd;
    endtask

    task automatic wr(input logic [1:0] tr, input logic [31:0] a, input logic [31:0] d,
                      input logic [2:0] sz);
        xfer(tr, a, 1'b1, sz, d, ws(), HRESP_OKAY, 1'b0, 32'h0);
    endtask

    task automatic rd(input logic [1:0] tr, input logic [31:0] a, input logic [31:0] want);
        xfer(tr, a, 1'b0, HSIZE_WORD, 32'h0, ws(), HRESP_OKAY, 1'b1, want);
    endtask

    task automatic idle();
        xfer(T_IDLE, 32'h0, 1'b0, HSIZE_WORD, 32'h0, 0, HRESP_OKAY, 1'b0, 32'h0);
    endtask

    task automatic err(input logic [31:0] a, input logic w, input logic [2:0] sz,
                       input logic chk, input logic [31:0] want);
        xfer(T_NONSEQ, a, w, sz, 32'hBAD0_BAD0, 1, HRESP_ERROR, chk, want);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 100) begin
            @(posedge hclk);
            n++;
        end
        if (exp_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: %0d responses outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
        @(posedge hclk);
        #1;
    endtask

    // Monitor: count low-hready cycles of the current data phase, compare on completion
    initial begin
        int low;
        low = 0;
        forever begin
            @(negedge hclk);
            if (!hresetn || exp_q.size() == 0) begin
                low = 0;
            end else if (!hready_m) begin
                low++;
                check($sformatf("hresp_in_wait xfer%0d", exp_q[0].tag), 32'(hresp_m),
                      32'(exp_q[0].resp));
                if (low > 30) begin
                    check($sformatf("wait_overrun xfer%0d", exp_q[0].tag), 32'(low),
                          32'(exp_q[0].waits));
                    void'(exp_q.pop_front());
                    low = 0;
                end
            end else begin
                check($sformatf("waits xfer%0d", exp_q[0].tag), 32'(low), 32'(exp_q[0].waits));
                check($sformatf("hresp xfer%0d", exp_q[0].tag), 32'(hresp_m), 32'(exp_q[0].resp));
                if (exp_q[0].chk) begin
                    check($sformatf("hrdata xfer%0d", exp_q[0].tag), hrdata_m, exp_q[0].data);
                end
                $display("xfer %0d complete: waits=%0d hresp=%0b hrdata=0x%08h",
                         exp_q[0].tag, low, hresp_m, hrdata_m);
                void'(exp_q.pop_front());
                low = 0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        repeat (2) @(posedge hclk);
        #1;
        check("rst_hready0", 32'(hready0), 32'h1);
        check("rst_hresp0",  32'(hresp0),  32'h0);
        check("rst_hrdata0", hrdata0,      32'h0);
        check("rst_hready2", 32'(hready2), 32'h1);
        check("rst_hresp2",  32'(hresp2),  32'h0);
        check("rst_hrdata2", hrdata2,      32'h0);
        hresetn = 1'b1;

        // Zero wait states: write then immediately read the same word
        wr(T_NONSEQ, 32'h4, 32'hDEAD_BEEF, HSIZE_WORD);
        rd(T_NONSEQ, 32'h4, 32'hDEAD_BEEF);
        idle();
        drain();

        // Byte lanes
        wr(T_NONSEQ, 32'h0, 32'hFFFF_FFFF, HSIZE_WORD);
        wr(T_NONSEQ, 32'h2, 32'h00AB_0000, HSIZE_BYTE);
        rd(T_NONSEQ, 32'h0, 32'hFFAB_FFFF);
        wr(T_NONSEQ, 32'h0, 32'h0000_1234, HSIZE_HALF);
        rd(T_NONSEQ, 32'h0, 32'hFFAB_1234);
        idle();
        drain();

        // Errors: out of range, IDLE after ERR2, misaligned, oversize; hrdata held
        err(32'h400, 1'b1, HSIZE_WORD, 1'b0, 32'h0);
        idle();
        err(32'h1, 1'b1, HSIZE_WORD, 1'b0, 32'h0);
        err(32'h2, 1'b0, HSIZE_WORD, 1'b1, 32'hFFAB_1234);
        err(32'h0, 1'b1, 3'b011, 1'b0, 32'h0);
        idle();
        rd(T_NONSEQ, 32'h0, 32'hFFAB_1234);
        idle();
        drain();

        // INCR4 write with a BUSY in the middle, then read back as a burst
        wr(T_NONSEQ, 32'h10, 32'hA000_0010, HSIZE_WORD);
        wr(T_SEQ,    32'h14, 32'hA100_0014, HSIZE_WORD);
        xfer(T_BUSY, 32'h18, 1'b1, HSIZE_WORD, hwdata, 0, HRESP_OKAY, 1'b0, 32'h0);
        wr(T_SEQ,    32'h18, 32'hA200_0018, HSIZE_WORD);
        wr(T_SEQ,    32'h1C, 32'hA300_001C, HSIZE_WORD);
        rd(T_NONSEQ, 32'h10, 32'hA000_0010);
        rd(T_SEQ,    32'h14, 32'hA100_0014);
        rd(T_SEQ,    32'h18, 32'hA200_0018);
        rd(T_SEQ,    32'h1C, 32'hA300_001C);
        idle();
        drain();

        // Two wait states
        sel = 1'b1;
        wr(T_NONSEQ, 32'h8, 32'h1234_5678, HSIZE_WORD);
        rd(T_NONSEQ, 32'h8, 32'h1234_5678);
        idle();
        err(32'h400, 1'b1, HSIZE_WORD, 1'b0, 32'h0);
        idle();
        wr(T_NONSEQ, 32'h20, 32'h1111_1111, HSIZE_WORD);
        rd(T_NONSEQ, 32'h20, 32'h1111_1111);
        idle();
        drain();

        // Reset in the middle of a waited write
        haddr  = 32'h20;
        htrans = T_NONSEQ;
        hwrite = 1'b1;
        hsize  = HSIZE_WORD;
        @(posedge hclk);
        #1;
        htrans = T_IDLE;
        hwdata = 32'hCAFE_F00D;
        @(negedge hclk);
        check("abort_in_wait_hready", 32'(hready_m), 32'h0);
        #1 hresetn = 1'b0;
        #1;
        check("abort_rst_hready", 32'(hready2), 32'h1);
        check("abort_rst_hresp",  32'(hresp2),  32'h0);
        check("abort_rst_hrdata", hrdata2,      32'h0);
        @(posedge hclk);
        #1 hresetn = 1'b1;
        rd(T_NONSEQ, 32'h20, 32'h1111_1111);
        rd(T_NONSEQ, 32'h8,  32'h1234_5678);
        idle();
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
